// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// UART receiver: 2-flop input synchronizer, oversampled mid-bit sampling,
// 8N1 or 8E1 framing, one-clk valid strobe with parity and framing flags.
//
// state  | meaning
// IDLE   | line idle; waits for rx_s low (or for rx_s high after a break)
// START  | counting to mid start bit to confirm or reject the start
// DATA   | sampling 8 data bits, LSB first, one per OVERSAMPLE ticks
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit
// DONE   | publishing byte and flags with a one-clk rx_valid
module uart_rx #(
  parameter int PARITY_EN  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       os_tick,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t        state;
  logic          rx_meta;
  logic          rx_s;
  logic [CW-1:0] os_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic          stop_bit;
  logic          wait_high;

  // Two-flop synchronizer; presets to idle-high so reset never looks like a start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_line;
      rx_s    <= rx_meta;
    end
  end

  // Frame state machine with registered outputs; busy mirrors the previous
  // clk's state so it stays high through the rx_valid cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      stop_bit   <= 1'b1;
      wait_high  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_busy  <= (state != IDLE);
      case (state)
        IDLE: begin
          // After a break the line must go high again before re-arming.
          if (wait_high) begin
            if (rx_s) wait_high <= 1'b0;
          end else if (!rx_s) begin
            state  <= START;
            os_cnt <= '0;
          end
        end
        START: if (os_tick) begin
          if (os_cnt == MID_CNT) begin
            os_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        DATA: if (os_tick) begin
          if (os_cnt == LAST_CNT) begin
            os_cnt    <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        PARITY: if (os_tick) begin
          if (os_cnt == LAST_CNT) begin
            os_cnt  <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        STOP: if (os_tick) begin
          if (os_cnt == LAST_CNT) begin
            os_cnt   <= '0;
            stop_bit <= rx_s;
            state    <= DONE;
          end else begin
            os_cnt <= os_cnt + 1'b1;
          end
        end
        DONE: begin
          rx_data    <= shift_reg;
          parity_err <= (PARITY_EN != 0) && (par_bit != (^shift_reg));
          frame_err  <= ~stop_bit;
          wait_high  <= ~stop_bit;
          rx_valid   <= 1'b1;
          os_cnt     <= '0;
          state      <= IDLE;
        end
        default: begin
          state  <= IDLE;
          os_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// Bench for uart_rx: drives serial frames in real time against a parity
// DUT and a no-parity DUT, and checks each delivered byte against a model.
module tb_uart_rx;

  localparam int  TICK_DIV = 4;
  localparam real BIT_NS   = 16.0 * TICK_DIV * 10.0;

  logic clk = 1'b0, rst_n = 1'b0, os_tick = 1'b0;
  logic rx_line = 1'b1, rx_line_np = 1'b1;
  logic [7:0] rx_data, rx_data_np;
  logic rx_valid, parity_err, frame_err, rx_busy;
  logic rx_valid_np, parity_err_np, frame_err_np, rx_busy_np;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } obs_t;

  obs_t obs_q[$];
  obs_t obs_np_q[$];
  logic prev_valid = 1'b0;
  logic busy_after = 1'b1;

  uart_rx #(.PARITY_EN(1), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_line(rx_line),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .rx_busy(rx_busy)
  );

  uart_rx #(.PARITY_EN(0), .OVERSAMPLE(16)) dut_np (
    .clk(clk), .rst_n(rst_n), .os_tick(os_tick), .rx_line(rx_line_np),
    .rx_data(rx_data_np), .rx_valid(rx_valid_np), .parity_err(parity_err_np),
    .frame_err(frame_err_np), .rx_busy(rx_busy_np)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #1;
      os_tick = (div == TICK_DIV - 1);
      div = (div + 1) % TICK_DIV;
    end
  end

  // Capture every delivered byte plus busy on and after the valid cycle.
  always @(negedge clk) begin
    if (prev_valid) busy_after <= rx_busy;
    prev_valid <= rx_valid;
    if (rx_valid) obs_q.push_back({rx_data, parity_err, frame_err, rx_busy});
    if (rx_valid_np) obs_np_q.push_back({rx_data_np, parity_err_np, frame_err_np, rx_busy_np});
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: even parity means the parity bit equals the count of ones mod 2.
  function automatic logic exp_perr(input logic [7:0] b, input logic par, input bit par_en);
    int ones;
    ones = $countones(b);
    return (par_en && (par != ones[0])) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic even_par(input logic [7:0] b);
    int ones;
    ones = $countones(b);
    return ones[0];
  endfunction

  task automatic set_line(input bit sel, input logic v);
    if (sel) rx_line_np = v;
    else rx_line = v;
  endtask

  // Leaves the line at the stop value; callers restore high after a bad stop.
  task automatic send_frame(input bit sel, input logic [7:0] b, input bit use_par,
                            input logic par, input logic stop, input real bit_ns);
    set_line(sel, 1'b0);
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, b[i]);
      #(bit_ns);
    end
    if (use_par) begin
      set_line(sel, par);
      #(bit_ns);
    end
    set_line(sel, stop);
    #(bit_ns);
  endtask

  task automatic wait_obs(input bit sel, input int n, input int max_clk, output bit ok);
    int sz;
    ok = 1'b0;
    for (int i = 0; i < max_clk; i++) begin
      sz = sel ? obs_np_q.size() : obs_q.size();
      if (sz >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", rx_valid); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", rx_busy); end
    n = obs_q.size();
    rx_line = 1'b0;
    repeat (20) @(posedge os_tick);
    @(posedge clk); #1;
    rst_n = 1'b0;
    rx_line = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #(2.0 * BIT_NS);
    @(negedge clk);
    checks++; if (obs_q.size() !== n) begin errors++; $display("FAIL midreset_novalid got %0d want %0d", obs_q.size(), n); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", rx_busy); end
    checks++; if ({rx_data, parity_err, frame_err} !== 10'h000) begin errors++; $display("FAIL midreset_outs got %h want 000", {rx_data, parity_err, frame_err}); end
  endtask

  task automatic test_clean;
    int n; bit ok;
    n = obs_q.size();
    send_frame(0, 8'hA5, 1, 1'b0, 1'b1, BIT_NS);
    wait_obs(0, n + 1, 400, ok);
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL clean_timeout got no valid want 1"); end
    else begin
      checks++; if (obs_q.size() !== n + 1) begin errors++; $display("FAIL clean_count got %0d want %0d", obs_q.size(), n + 1); end
      checks++; if (obs_q[n].data !== 8'hA5) begin errors++; $display("FAIL clean_data got %h want a5", obs_q[n].data); end
      checks++; if (obs_q[n].perr !== exp_perr(8'hA5, 1'b0, 1)) begin errors++; $display("FAIL clean_perr got %b want 0", obs_q[n].perr); end
      checks++; if (obs_q[n].ferr !== 1'b0) begin errors++; $display("FAIL clean_ferr got %b want 0", obs_q[n].ferr); end
      checks++; if (obs_q[n].busy !== 1'b1) begin errors++; $display("FAIL clean_busy_on_valid got %b want 1", obs_q[n].busy); end
      checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL clean_busy_after got %b want 0", busy_after); end
    end
  endtask

  task automatic test_bad_parity;
    int n; bit ok;
    n = obs_q.size();
    send_frame(0, 8'h07, 1, 1'b0, 1'b1, BIT_NS);
    wait_obs(0, n + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL badpar_timeout got no valid want 1"); end
    else begin
      checks++; if (obs_q[n].data !== 8'h07) begin errors++; $display("FAIL badpar_data got %h want 07", obs_q[n].data); end
      checks++; if (obs_q[n].perr !== exp_perr(8'h07, 1'b0, 1)) begin errors++; $display("FAIL badpar_perr got %b want 1", obs_q[n].perr); end
      checks++; if (obs_q[n].ferr !== 1'b0) begin errors++; $display("FAIL badpar_ferr got %b want 0", obs_q[n].ferr); end
    end
  endtask

  task automatic test_bad_stop;
    int n; bit ok;
    n = obs_q.size();
    send_frame(0, 8'h3C, 1, even_par(8'h3C), 1'b0, BIT_NS);
    wait_obs(0, n + 1, 400, ok);
    #(3.0 * BIT_NS);
    checks++; if (obs_q.size() !== n + 1) begin errors++; $display("FAIL badstop_count_low got %0d want %0d", obs_q.size(), n + 1); end
    rx_line = 1'b1;
    #(BIT_NS);
    checks++; if (obs_q.size() !== n + 1) begin errors++; $display("FAIL badstop_count_high got %0d want %0d", obs_q.size(), n + 1); end
    if (ok) begin
      checks++; if (obs_q[n].data !== 8'h3C) begin errors++; $display("FAIL badstop_data got %h want 3c", obs_q[n].data); end
      checks++; if (obs_q[n].ferr !== 1'b1) begin errors++; $display("FAIL badstop_ferr got %b want 1", obs_q[n].ferr); end
      checks++; if (obs_q[n].perr !== 1'b0) begin errors++; $display("FAIL badstop_perr got %b want 0", obs_q[n].perr); end
    end
  endtask

  task automatic test_false_start;
    int n; bit ok;
    n = obs_q.size();
    rx_line = 1'b0;
    repeat (5) @(posedge os_tick);
    rx_line = 1'b1;
    repeat (10) @(posedge os_tick);
    repeat (3) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_busy got %b want 0", rx_busy); end
    #(BIT_NS);
    checks++; if (obs_q.size() !== n) begin errors++; $display("FAIL false_start_novalid got %0d want %0d", obs_q.size(), n); end
    send_frame(0, 8'h5A, 1, even_par(8'h5A), 1'b1, BIT_NS);
    wait_obs(0, n + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL false_start_timeout got no valid want 1"); end
    else begin
      checks++; if (obs_q[n].data !== 8'h5A) begin errors++; $display("FAIL false_start_data got %h want 5a", obs_q[n].data); end
      checks++; if ({obs_q[n].perr, obs_q[n].ferr} !== 2'b00) begin errors++; $display("FAIL false_start_flags got %b want 00", {obs_q[n].perr, obs_q[n].ferr}); end
    end
  endtask

  task automatic test_break;
    int n;
    n = obs_q.size();
    rx_line = 1'b0;
    #(15.0 * BIT_NS);
    rx_line = 1'b1;
    #(2.0 * BIT_NS);
    checks++; if (obs_q.size() !== n + 1) begin errors++; $display("FAIL break_count got %0d want %0d", obs_q.size(), n + 1); end
    if (obs_q.size() > n) begin
      checks++; if (obs_q[n].data !== 8'h00) begin errors++; $display("FAIL break_data got %h want 00", obs_q[n].data); end
      checks++; if ({obs_q[n].perr, obs_q[n].ferr} !== 2'b01) begin errors++; $display("FAIL break_flags got %b want 01", {obs_q[n].perr, obs_q[n].ferr}); end
    end
  endtask

  task automatic test_random;
    int n; bit ok;
    logic [7:0] b; logic par; logic stop;
    for (int k = 0; k < 8; k++) begin
      b    = 8'($urandom_range(0, 255));
      par  = even_par(b) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      n = obs_q.size();
      send_frame(0, b, 1, par, stop, BIT_NS);
      wait_obs(0, n + 1, 400, ok);
      if (!stop) begin
        rx_line = 1'b1;
        #(BIT_NS);
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL random_timeout frame %0d got no valid want 1", k); end
      else if (obs_q[n] [10:1] !== {b, exp_perr(b, par, 1), ~stop}) begin
        errors++;
        $display("FAIL random_frame %0d got data %h perr %b ferr %b want data %h perr %b ferr %b",
                 k, obs_q[n].data, obs_q[n].perr, obs_q[n].ferr, b, exp_perr(b, par, 1), ~stop);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n; bit ok;
    logic [7:0] bytes [4];
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81; bytes[3] = 8'($urandom_range(0, 255));
    n = obs_np_q.size();
    for (int i = 0; i < 4; i++) send_frame(1, bytes[i], 0, 1'b0, 1'b1, BIT_NS * 1.02);
    wait_obs(1, n + 4, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_count got %0d want %0d", obs_np_q.size(), n + 4); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_np_q[n + i] [10:1] !== {bytes[i], 2'b00}) begin
          errors++;
          $display("FAIL b2b_frame %0d got data %h perr %b ferr %b want data %h perr 0 ferr 0",
                   i, obs_np_q[n + i].data, obs_np_q[n + i].perr, obs_np_q[n + i].ferr, bytes[i]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset;
    test_clean;
    test_bad_parity;
    test_bad_stop;
    test_false_start;
    test_break;
    test_random;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the stage directly downstream of the UART transmitter; consumes the serial line that the transmitter drives.
- Frame format matches the transmitter: start bit (0), 8 data bits LSB first, optional even parity bit (XOR of the data), stop bit (1).
- Samples the line on a 16x oversampling tick, resolves each bit at mid-bit, and presents each byte with a one-cycle valid strobe plus error flags.

Parameters:
- PARITY_EN, 1, 1 = expect and check a parity bit after the data bits; 0 = no parity bit.
- OVERSAMPLE, 16, os_tick pulses per bit period. Must be even and at least 8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- os_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate
- rx_line  input  1  asynchronous serial input; idles high
- rx_data  output  8  last received byte; held until the next byte completes
- rx_valid  output  1  one-clk pulse when rx_data, parity_err and frame_err update
- parity_err  output  1  parity mismatch on the last byte (0 when PARITY_EN=0)
- frame_err  output  1  stop bit sampled low on the last byte
- rx_busy  output  1  high in every state except IDLE

Behaviour:
- Interface is decided: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; rx_data=0, rx_valid=0, parity_err=0, frame_err=0, rx_busy=0.
  - Synchronizer flops preset to 1.
  - Reset mid-frame aborts the frame; no rx_valid is produced.
- Input synchronisation:
  - rx_line passes through two flops to give rx_s.
  - All decisions use rx_s, so there are 2 clk of latency.
- Tick counter, os_cnt (4 bits for the default):
  - Advances only on os_tick.
  - Cleared on every state transition.
- State machine (all states except IDLE act only on os_tick cycles):
  - IDLE: when rx_s=0 (no os_tick needed), go to START and clear os_cnt.
  - START:
    - When os_cnt reaches OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - rx_s=1 means a false start (glitch): return to IDLE, no flags, no valid.
    - rx_s=0 means start confirmed: go to DATA and clear bit_cnt.
  - DATA:
    - Every OVERSAMPLE ticks (os_cnt==OVERSAMPLE-1), shift rx_s into shift_reg[7] with a right shift, so the first bit received ends in bit 0.
    - Increment bit_cnt.
    - After the 8th sample, go to PARITY if PARITY_EN, otherwise to STOP.
  - PARITY: after OVERSAMPLE ticks, sample rx_s into par_bit; go to STOP.
  - STOP:
    - After OVERSAMPLE ticks, sample rx_s.
    - On the next clk: rx_data=shift_reg; parity_err=(par_bit != ^shift_reg) & PARITY_EN; frame_err=~rx_s; rx_valid=1 for exactly one clk.
    - Then go to IDLE.
    - Sampling at mid-bit lets the next start bit be detected half a bit early, so back-to-back frames are received without loss.
- Error handling:
  - Flags are delivered with rx_valid and hold until the next rx_valid.
  - A byte with an error is still delivered on rx_data.
- Line held low (break condition):
  - Produces a frame with data 0x00 and frame_err=1.
  - The block then stays in IDLE until rx_s returns high before re-arming, so a held-low line yields no repeated frames.
- No handshake or backpressure: the consumer must take rx_data on the rx_valid cycle or read the held value before the next frame.
- os_tick and a state event in the same cycle: the transition takes priority and os_cnt restarts from 0.

Test Plan:
- Reset mid-frame: drive rx_line low for 20 os_ticks, then rst_n=0 for 2 clk, then release with the line high → all outputs 0, state IDLE, no rx_valid.
- Clean frame, 0xA5 with parity 0 and stop 1, OVERSAMPLE=16 → one rx_valid pulse; rx_data=0xA5, parity_err=0, frame_err=0; rx_busy falls the cycle after rx_valid.
- Bad parity: 0x07 sent with parity 0 (the correct value is 1) → rx_data=0x07, parity_err=1, frame_err=0.
- Bad stop bit: 0x3C sent with the stop bit held 0, then the line returns high → rx_data=0x3C, frame_err=1; exactly one rx_valid, and none further while the line is low.
- False start: a low glitch of 5 os_ticks, then high → no rx_valid, rx_busy returns to 0 at mid start bit. Then a valid 0x5A is received correctly.
- Back-to-back frames: 0x00, 0xFF, 0x81 with no idle gap, PARITY_EN=0, plus 2% baud skew → three rx_valid pulses carrying the correct bytes and no error flags.
